// File: rtl/rr_mux4_scheduler.sv
// Round-robin 4-source scheduler feeding the 4:1 nibble mux through a registered valid/ready stage.
// Define RR_FIXED_PRIO_EN for fixed priority (channel 0 highest) with no rotating pointer.
module rr_mux4_scheduler_lane (
   input  logic req,
   input  logic is_sel,
   input  logic xfer,
   output logic elig,
   output logic grant
);
   // The source leaving on this edge is masked so it is never reloaded with a stale word.
   assign grant = is_sel & xfer;
   assign elig  = req & ~grant;
endmodule

module rr_mux4_scheduler #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   req,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   input  logic [W-1:0] d,
   output logic [1:0]   sel,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [3:0]   grant
);
   typedef enum logic {IDLE, HOLD} state_t;

   state_t              state;
   logic [3:0][W-1:0]   chan;
   logic [3:0]          sel_oh;
   logic [3:0]          elig;
   logic                xfer;
   logic [1:0]          base;
   logic [1:0]          cand;
   logic [1:0]          idx;
   logic                hit;

   assign chan   = {d, c, b, a};
   assign xfer   = out_valid & out_ready;
   assign sel_oh = 4'b0001 << sel;
   assign hit    = |elig;

   for (genvar i = 0; i < 4; i++) begin : g_lane
      rr_mux4_scheduler_lane u_lane (
         .req    (req[i]),
         .is_sel (sel_oh[i]),
         .xfer   (xfer),
         .elig   (elig[i]),
         .grant  (grant[i])
      );
   end

`ifdef RR_FIXED_PRIO_EN
   assign base = 2'd0;
`else
   logic [1:0] ptr;
   // On a transfer the scan starts from the pointer value being written this edge.
   assign base = xfer ? sel + 2'd1 : ptr;
`endif

   always_comb begin
      cand = '0;
      idx  = '0;
      for (int k = 3; k >= 0; k--) begin
         idx = base + 2'(k);
         if (elig[idx]) cand = idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         sel       <= '0;
`ifndef RR_FIXED_PRIO_EN
         ptr       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  sel       <= cand;
                  out_data  <= chan[cand];
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
`ifndef RR_FIXED_PRIO_EN
                  ptr <= sel + 2'd1;
`endif
                  if (hit) begin
                     sel      <= cand;
                     out_data <= chan[cand];
                  end else begin
                     out_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule
